// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: definitions shared by the memory arbiter and its bench.
//   arb_state_e  : 2-bit FSM encoding (IDLE=0, ACCESS=1, RESP=2)
//   ADDR_W_DEF   : default memory word-address width
//   DATA_W_DEF   : default data width
//   CNT_W        : latency counter width (covers MEM_LAT up to 15)
//   data_wins()  : round-robin winner selection between the two ports
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 4;

    // Returns 1 when the data port wins. A lone requester always wins; on a
    // tie the port that was not granted last time wins.
    function automatic logic data_wins(input logic i_req,
                                       input logic d_req,
                                       input logic last_was_d);
        return d_req && (!i_req || !last_was_d);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between an
// instruction-fetch port (read only) and a data port (read/write).
//
// Ports:
//   clk, reset                          clock, async active-low reset
//   i_req, i_addr                       fetch request / address
//   i_ack, i_rdata                      fetch completion pulse / read data
//   d_req, d_we, d_addr, d_wdata        data request / write enable / address / write data
//   d_ack, d_rdata                      data completion pulse / read data
//   mem_en, mem_we, mem_addr, mem_wdata memory command
//   mem_rdata                           memory read data (valid MEM_LAT cycles after mem_en rises)
//   busy, owner_d                       access in progress / owner (1 = data port)
//   state_dbg                           current FSM state, for observation only
//
// Handshake: a requester raises req with stable operands and holds them until
// its ack pulse. Requests are sampled only in IDLE; anything raised while busy
// waits. Once granted, the access always completes (dropping req does not
// abort it). An ack is a single-cycle pulse and read data is valid only in
// that cycle. Timeline: sampled at t, ACCESS t+1..t+MEM_LAT, ack at
// t+MEM_LAT+1, back in IDLE at t+MEM_LAT+2.
//
// MEM_LAT must be in 1..15 so that MEM_LAT-1 fits the 4-bit counter.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner_d,
    output arb_state_e        state_dbg
);

    arb_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              owner_q;
    logic              last_d_q;   // 1 when the most recent grant went to the data port
    logic              win_d;

    assign win_d = data_wins(i_req, d_req, last_d_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            owner_q  <= 1'b0;
            last_d_q <= 1'b1;   // fetch wins the first tie after reset
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        owner_q  <= win_d;
                        last_d_q <= win_d;
                        if (win_d) begin
                            addr_q  <= d_addr;
                            wdata_q <= d_wdata;
                            we_q    <= d_we;
                        end else begin
                            addr_q  <= i_addr;
                            wdata_q <= '0;
                            we_q    <= 1'b0;
                        end
                        cnt_q   <= CNT_W'(MEM_LAT - 1);
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        // Writes leave rdata_q untouched so the last read survives.
                        if (!we_q) begin
                            rdata_q <= mem_rdata;
                        end
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from registers, so reset clears them at once.
    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = (state_q == ST_ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign owner_d   = owner_q;
    assign i_ack     = (state_q == ST_RESP) && !owner_q;
    assign d_ack     = (state_q == ST_RESP) && owner_q;
    assign i_rdata   = rdata_q;
    assign d_rdata   = rdata_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;
  localparam int LAT1   = 1;
  localparam logic [DATA_W-1:0] GARBAGE = 32'h0BAD_0BAD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (MEM_LAT=2) ----------------
  logic              i_req, i_ack, d_req, d_we, d_ack;
  logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
  logic [DATA_W-1:0] i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic              mem_en, mem_we, busy, owner_d;
  arb_state_e        state_dbg;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner_d(owner_d), .state_dbg(state_dbg)
  );

  // ---------------- DUT (MEM_LAT=1) ----------------
  logic              l_i_req, l_i_ack, l_d_req, l_d_we, l_d_ack;
  logic [ADDR_W-1:0] l_i_addr, l_d_addr, l_mem_addr;
  logic [DATA_W-1:0] l_i_rdata, l_d_wdata, l_d_rdata, l_mem_wdata, l_mem_rdata;
  logic              l_mem_en, l_mem_we, l_busy, l_owner_d;
  arb_state_e        l_state_dbg;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT1)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(l_i_req), .i_addr(l_i_addr), .i_ack(l_i_ack), .i_rdata(l_i_rdata),
    .d_req(l_d_req), .d_we(l_d_we), .d_addr(l_d_addr), .d_wdata(l_d_wdata),
    .d_ack(l_d_ack), .d_rdata(l_d_rdata),
    .mem_en(l_mem_en), .mem_we(l_mem_we), .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata),
    .mem_rdata(l_mem_rdata), .busy(l_busy), .owner_d(l_owner_d), .state_dbg(l_state_dbg)
  );

  // ---------------- memory model ----------------
  // Read data becomes valid only after mem_en has been high for the full
  // latency; before that the model returns a garbage pattern.
  logic [DATA_W-1:0] mem_arr [256];
  int en_cnt = 0;
  int l_en_cnt = 0;

  always @(posedge clk) begin
    en_cnt   <= mem_en   ? en_cnt + 1   : 0;
    l_en_cnt <= l_mem_en ? l_en_cnt + 1 : 0;
  end

  always_comb begin
    mem_rdata = GARBAGE;
    if (mem_en && en_cnt >= LAT - 1) mem_rdata = mem_arr[mem_addr[7:0]];
    l_mem_rdata = GARBAGE;
    if (l_mem_en && l_en_cnt >= LAT1 - 1) l_mem_rdata = mem_arr[l_mem_addr[7:0]];
  end

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_v;
  int total = 0;
  int bad = 0;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    l_i_req = 1'b0; l_i_addr = '0;
    l_d_req = 1'b0; l_d_we = 1'b0; l_d_addr = '0; l_d_wdata = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Advances until an ack appears on the MEM_LAT=2 DUT, recording what the
  // memory command looked like along the way. A timeout is a failure.
  task automatic wait_ack(input int budget,
                          output int cyc, output logic ia, output logic da,
                          output logic [DATA_W-1:0] ird, output logic [DATA_W-1:0] drd,
                          output logic own, output int en_cyc,
                          output logic [ADDR_W-1:0] ea, output logic ew,
                          output logic [DATA_W-1:0] ewd, output logic stable);
    cyc = 0; ia = 1'b0; da = 1'b0; ird = '0; drd = '0; own = 1'b0;
    en_cyc = 0; ea = '0; ew = 1'b0; ewd = '0; stable = 1'b1;
    for (int k = 0; k < budget; k++) begin
      step();
      cyc++;
      if (mem_en) begin
        if (en_cyc == 0) begin
          ea = mem_addr; ew = mem_we; ewd = mem_wdata; own = owner_d;
        end else if (mem_addr !== ea || mem_we !== ew || mem_wdata !== ewd || owner_d !== own) begin
          stable = 1'b0;
        end
        en_cyc++;
      end
      if (i_ack || d_ack) begin
        ia = i_ack; da = d_ack; ird = i_rdata; drd = d_rdata;
        break;
      end
    end
    if (!(ia || da)) begin
      total++; bad++;
      $display("FAIL ack_timeout: no ack within %0d cycles", budget);
    end
  endtask

  // ---------------- tests ----------------
  int cyc, en_cyc;
  logic ia, da, own, ew, stable;
  logic [DATA_W-1:0] ird, drd, ewd;
  logic [ADDR_W-1:0] ea;

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_en_we got=%b%b exp=00", mem_en, mem_we); end
    total++; if (i_ack !== 1'b0 || d_ack !== 1'b0) begin bad++; $display("FAIL rst_acks got=%b%b exp=00", i_ack, d_ack); end
    total++; if (mem_addr !== '0 || mem_wdata !== '0) begin bad++; $display("FAIL rst_mem_cmd got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    total++; if (i_rdata !== '0 || d_rdata !== '0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0/0", i_rdata, d_rdata); end
    total++; if (owner_d !== 1'b0) begin bad++; $display("FAIL rst_owner got=%b exp=0", owner_d); end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
    step();
    reset = 1'b1;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_idle got=%b exp=0", busy); end
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 16'h0010;
    exp_q.push_back(mem_arr[8'h10]);
    wait_ack(20, cyc, ia, da, ird, drd, own, en_cyc, ea, ew, ewd, stable);
    i_req = 1'b0;
    exp_v = exp_q.pop_front();
    total++; if (cyc !== LAT + 1) begin bad++; $display("FAIL fetch_latency got=%0d exp=%0d", cyc, LAT + 1); end
    total++; if (ia !== 1'b1 || da !== 1'b0) begin bad++; $display("FAIL fetch_acks got=i%b d%b exp=i1 d0", ia, da); end
    total++; if (ird !== exp_v) begin bad++; $display("FAIL fetch_rdata got=%h exp=%h", ird, exp_v); end
    total++; if (en_cyc !== LAT) begin bad++; $display("FAIL fetch_en_cycles got=%0d exp=%0d", en_cyc, LAT); end
    total++; if (ea !== 16'h0010 || ew !== 1'b0 || own !== 1'b0) begin bad++; $display("FAIL fetch_cmd got=a%h we%b own%b exp=a0010 we0 own0", ea, ew, own); end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL fetch_stable got=%b exp=1", stable); end
    step();
    total++; if (busy !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("FAIL fetch_back_idle got=busy%b en%b exp=00", busy, mem_en); end
  endtask

  task automatic test_write();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 32'h1234_5678;
    exp_q.push_back(32'hDEAD_BEEF);   // prior read value must survive the write
    wait_ack(20, cyc, ia, da, ird, drd, own, en_cyc, ea, ew, ewd, stable);
    d_req = 1'b0; d_we = 1'b0;
    exp_v = exp_q.pop_front();
    total++; if (ia !== 1'b0 || da !== 1'b1) begin bad++; $display("FAIL write_acks got=i%b d%b exp=i0 d1", ia, da); end
    total++; if (cyc !== LAT + 1 || en_cyc !== LAT) begin bad++; $display("FAIL write_timing got=cyc%0d en%0d exp=cyc%0d en%0d", cyc, en_cyc, LAT + 1, LAT); end
    total++; if (ea !== 16'h0100 || ew !== 1'b1 || ewd !== 32'h1234_5678 || own !== 1'b1) begin bad++; $display("FAIL write_cmd got=a%h we%b wd%h own%b exp=a0100 we1 wd12345678 own1", ea, ew, ewd, own); end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL write_stable got=%b exp=1", stable); end
    total++; if (drd !== exp_v) begin bad++; $display("FAIL write_keeps_rdata got=%h exp=%h", drd, exp_v); end
    step();
  endtask

  task automatic test_data_read();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    exp_q.push_back(mem_arr[8'h20]);
    wait_ack(20, cyc, ia, da, ird, drd, own, en_cyc, ea, ew, ewd, stable);
    d_req = 1'b0;
    exp_v = exp_q.pop_front();
    total++; if (ia !== 1'b0 || da !== 1'b1) begin bad++; $display("FAIL dread_acks got=i%b d%b exp=i0 d1", ia, da); end
    total++; if (drd !== exp_v) begin bad++; $display("FAIL dread_rdata got=%h exp=%h", drd, exp_v); end
    total++; if (ea !== 16'h0020 || ew !== 1'b0) begin bad++; $display("FAIL dread_cmd got=a%h we%b exp=a0020 we0", ea, ew); end
    step();
  endtask

  task automatic test_round_robin();
    logic exp_d [3];
    int   exp_cyc [3];
    exp_d[0] = 1'b0; exp_d[1] = 1'b1; exp_d[2] = 1'b0;
    exp_cyc[0] = LAT + 1; exp_cyc[1] = LAT + 2; exp_cyc[2] = LAT + 2;
    pulse_reset();
    i_req = 1'b1; i_addr = 16'h0030;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
    for (int n = 0; n < 3; n++) exp_q.push_back(exp_d[n] ? mem_arr[8'h40] : mem_arr[8'h30]);
    for (int n = 0; n < 3; n++) begin
      wait_ack(20, cyc, ia, da, ird, drd, own, en_cyc, ea, ew, ewd, stable);
      if (n == 2) begin i_req = 1'b0; d_req = 1'b0; end
      exp_v = exp_q.pop_front();
      total++; if (da !== exp_d[n] || ia !== !exp_d[n]) begin bad++; $display("FAIL rr_grant%0d got=i%b d%b exp_d=%b", n, ia, da, exp_d[n]); end
      total++; if (cyc !== exp_cyc[n]) begin bad++; $display("FAIL rr_spacing%0d got=%0d exp=%0d", n, cyc, exp_cyc[n]); end
      total++; if ((exp_d[n] ? drd : ird) !== exp_v) begin bad++; $display("FAIL rr_rdata%0d got=%h exp=%h", n, exp_d[n] ? drd : ird, exp_v); end
      total++; if (en_cyc !== LAT || ea !== (exp_d[n] ? 16'h0040 : 16'h0030)) begin bad++; $display("FAIL rr_cmd%0d got=en%0d a%h", n, en_cyc, ea); end
    end
    step();
  endtask

  task automatic test_busy_request();
    i_req = 1'b1; i_addr = 16'h0050;
    exp_q.push_back(mem_arr[8'h50]);
    step();
    total++; if (busy !== 1'b1 || mem_en !== 1'b1) begin bad++; $display("FAIL busy_first_access got=busy%b en%b exp=11", busy, mem_en); end
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0060;
    exp_q.push_back(mem_arr[8'h60]);
    wait_ack(20, cyc, ia, da, ird, drd, own, en_cyc, ea, ew, ewd, stable);
    i_req = 1'b0;
    exp_v = exp_q.pop_front();
    total++; if (ia !== 1'b1 || da !== 1'b0 || cyc !== LAT) begin bad++; $display("FAIL busy_fetch got=i%b d%b cyc%0d exp=i1 d0 cyc%0d", ia, da, cyc, LAT); end
    total++; if (ird !== exp_v || own !== 1'b0 || stable !== 1'b1) begin bad++; $display("FAIL busy_fetch_data got=%h own%b st%b exp=%h own0 st1", ird, own, stable, exp_v); end
    wait_ack(20, cyc, ia, da, ird, drd, own, en_cyc, ea, ew, ewd, stable);
    d_req = 1'b0;
    exp_v = exp_q.pop_front();
    total++; if (da !== 1'b1 || ia !== 1'b0 || cyc !== LAT + 2) begin bad++; $display("FAIL busy_data_after got=i%b d%b cyc%0d exp=i0 d1 cyc%0d", ia, da, cyc, LAT + 2); end
    total++; if (drd !== exp_v || en_cyc !== LAT || ea !== 16'h0060 || own !== 1'b1) begin bad++; $display("FAIL busy_data_cmd got=%h en%0d a%h own%b exp=%h", drd, en_cyc, ea, own, exp_v); end
    step();
  endtask

  task automatic test_drop_req();
    i_req = 1'b1; i_addr = 16'h0070;
    exp_q.push_back(mem_arr[8'h70]);
    step();
    i_req = 1'b0;
    wait_ack(20, cyc, ia, da, ird, drd, own, en_cyc, ea, ew, ewd, stable);
    exp_v = exp_q.pop_front();
    total++; if (ia !== 1'b1 || cyc !== LAT || ird !== exp_v) begin bad++; $display("FAIL drop_req_ack got=i%b cyc%0d %h exp=i1 cyc%0d %h", ia, cyc, ird, LAT, exp_v); end
    step();
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_req_no_regrant got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic saw_ack;
    i_req = 1'b1; i_addr = 16'h0010;
    exp_q.push_back(mem_arr[8'h10]);
    step();
    step();
    total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL rmid_in_access got=%b exp=1", mem_en); end
    reset = 1'b0;
    #1;
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_drop got=en%b we%b busy%b exp=000", mem_en, mem_we, busy); end
    total++; if (i_rdata !== '0) begin bad++; $display("FAIL rmid_rdata_clr got=%h exp=0", i_rdata); end
    saw_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (i_ack || d_ack) saw_ack = 1'b1;
    end
    total++; if (saw_ack !== 1'b0) begin bad++; $display("FAIL rmid_no_ack got=%b exp=0", saw_ack); end
    reset = 1'b1;
    wait_ack(20, cyc, ia, da, ird, drd, own, en_cyc, ea, ew, ewd, stable);
    i_req = 1'b0;
    exp_v = exp_q.pop_front();
    total++; if (ia !== 1'b1 || cyc !== LAT + 1 || en_cyc !== LAT) begin bad++; $display("FAIL rmid_regrant got=i%b cyc%0d en%0d exp=i1 cyc%0d en%0d", ia, cyc, en_cyc, LAT + 1, LAT); end
    total++; if (ird !== exp_v) begin bad++; $display("FAIL rmid_rdata got=%h exp=%h", ird, exp_v); end
    step();
  endtask

  task automatic test_lat1();
    int l_cyc;
    int l_en;
    logic got;
    l_cyc = 0; l_en = 0; got = 1'b0;
    l_i_req = 1'b1; l_i_addr = 16'h0010;
    exp_q.push_back(mem_arr[8'h10]);
    for (int k = 0; k < 20; k++) begin
      step();
      l_cyc++;
      if (l_mem_en) l_en++;
      if (l_i_ack || l_d_ack) begin got = 1'b1; break; end
    end
    l_i_req = 1'b0;
    exp_v = exp_q.pop_front();
    total++; if (got !== 1'b1) begin bad++; $display("FAIL lat1_timeout got=%b exp=1", got); end
    total++; if (l_cyc !== LAT1 + 1) begin bad++; $display("FAIL lat1_latency got=%0d exp=%0d", l_cyc, LAT1 + 1); end
    total++; if (l_en !== LAT1) begin bad++; $display("FAIL lat1_en_cycles got=%0d exp=%0d", l_en, LAT1); end
    total++; if (l_i_ack !== 1'b1 || l_d_ack !== 1'b0 || l_i_rdata !== exp_v) begin bad++; $display("FAIL lat1_ack got=i%b d%b %h exp=i1 d0 %h", l_i_ack, l_d_ack, l_i_rdata, exp_v); end
    step();
    step();
    total++; if (l_busy !== 1'b0 || l_mem_we !== 1'b0) begin bad++; $display("FAIL lat1_idle got=busy%b we%b exp=00", l_busy, l_mem_we); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int a = 0; a < 256; a++) mem_arr[a] = {8'hA5, 8'(a), 16'($urandom_range(0, 65535))};
    mem_arr[8'h10] = 32'hDEAD_BEEF;
    mem_arr[8'h20] = 32'hCAFE_F00D;
    mem_arr[8'h30] = 32'h1111_2222;
    mem_arr[8'h40] = 32'h3333_4444;
    mem_arr[8'h50] = 32'h5555_0000;
    mem_arr[8'h60] = 32'h6666_0000;
    mem_arr[8'h70] = 32'h7777_0000;
    idle_inputs();
    test_reset();
    test_fetch();
    test_write();
    test_data_read();
    test_round_robin();
    test_busy_request();
    test_drop_req();
    test_reset_mid();
    test_lat1();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory word-address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MEM_LAT, default 2, cycles from mem_en assertion to valid mem_rdata; legal range 1..15.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 i_req / i_addr  in  1 / ADDR_W  instruction-fetch request and address (read only).
REQ-007 i_ack / i_rdata  out  1 / DATA_W  one-cycle fetch completion pulse and read data.
REQ-008 d_req / d_we / d_addr / d_wdata  in  1 / 1 / ADDR_W / DATA_W  data-port request, write enable, address and write data.
REQ-009 d_ack / d_rdata  out  1 / DATA_W  one-cycle data completion pulse and read data.
REQ-010 mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / ADDR_W / DATA_W  single-port memory command.
REQ-011 mem_rdata  in  DATA_W  memory read data.
REQ-012 busy / owner_d  out  1 / 1  access in progress; current owner (1 = data port, 0 = fetch port).

Function
REQ-013 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-014 IDLE: if no request is high, stay in IDLE; otherwise latch the winner's addr, we (forced 0 for fetch) and wdata, load the counter with MEM_LAT-1, and enter ACCESS.
REQ-015 Winner selection: a lone requester wins; if both are high, the port not granted last wins (round-robin); the last-grant register updates on every grant.
REQ-016 ACCESS: mem_en=1, and mem_we/mem_addr/mem_wdata come from the latched registers, held stable for exactly MEM_LAT cycles.
REQ-017 ACCESS: the counter decrements each cycle; when it reaches 0, capture mem_rdata into rdata_q on reads only and enter RESP.
REQ-018 RESP: pulse the owner's ack for one cycle, drive the other ack 0, then return to IDLE unconditionally.
REQ-019 i_rdata and d_rdata SHALL both equal rdata_q; they are valid only while the matching ack is high.
REQ-020 rdata_q SHALL hold its value across writes.
REQ-021 Latency: request sampled in IDLE at cycle t -> ACCESS in cycles t+1..t+MEM_LAT -> ack in cycle t+MEM_LAT+1 -> IDLE at t+MEM_LAT+2.
REQ-022 Throughput: one access per MEM_LAT+2 cycles.
REQ-023 Requests arriving while busy are not registered; they are sampled only in IDLE, so requesters hold req and operands stable until ack.
REQ-024 A req dropped after grant SHALL NOT abort the access; the ack still pulses.
REQ-025 busy=1 in ACCESS and RESP; owner_d is valid while busy.
REQ-026 mem_en=0 and mem_we=0 in every state except ACCESS.

Reset
REQ-027 While reset=0, asynchronously: state=IDLE, counter=0, rdata_q=0, latched addr/wdata/we=0, and last-grant=data, so fetch wins the first tie.
REQ-028 All outputs SHALL be 0 while reset is asserted.
REQ-029 Reset mid-ACCESS SHALL drop mem_en/mem_we immediately with no ack; the access is lost and requesters must re-request.

Structure
REQ-030 Shared package mem_arb_pkg SHALL hold the state encoding (2-bit: IDLE=0, ACCESS=1, RESP=2) and the default ADDR_W/DATA_W constants.
REQ-031 Counter width SHALL be 4 bits, sized for MEM_LAT up to 15.
REQ-032 Arbitration and FSM SHALL be in a single module; no sub-module is required.

Verification (MEM_LAT=2)
REQ-033 Fetch only: i_req=1, i_addr=0x0010, mem returns 0xDEADBEEF -> mem_en high for 2 cycles with addr 0x0010, mem_we=0; i_ack pulses 3 cycles after sampling with i_rdata=0xDEADBEEF; d_ack stays 0.
REQ-034 Simultaneous requests after reset: i_req=d_req=1 held -> fetch granted first, then data, then fetch; grants alternate, one per 4 cycles.
REQ-035 Data write: d_we=1, d_addr=0x0100, d_wdata=0x12345678 -> mem_we=1 with that addr/data for 2 cycles; d_ack pulses; rdata_q keeps the prior read value.
REQ-036 Request during busy: d_req raised during a fetch's ACCESS -> ignored until IDLE, then granted; no overlap of mem_en between owners.
REQ-037 Reset mid-ACCESS: reset=0 in the second ACCESS cycle -> mem_en=0 immediately, no ack; after release a held i_req is re-granted from IDLE.
REQ-038 MEM_LAT=1 build: single-request latency is exactly 2 cycles to ack; mem_en is high for 1 cycle.
